// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-master RAM arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_WIDTH = 64;
    localparam int MEM_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/Mem_ift.sv
// Split read/write memory port: master drives Mr/Mw, slave answers on Sr/Sw.
interface Mem_ift
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
);

    typedef struct packed {
        logic                    ren;
        logic [ADDR_WIDTH-1:0]   raddr;
    } mr_t;

    typedef struct packed {
        logic                    wen;
        logic [ADDR_WIDTH-1:0]   waddr;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [DATA_WIDTH/8-1:0] wmask;
    } mw_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   rdata;
        logic                    rvalid;
    } sr_t;

    typedef struct packed {
        logic                    wvalid;
    } sw_t;

    mr_t Mr;
    mw_t Mw;
    sr_t Sr;
    sw_t Sw;

    modport Master (output Mr, output Mw, input Sr, input Sw);
    modport Slave  (input Mr, input Mw, output Sr, output Sw);

endinterface

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin pick: a tie goes to whoever did not own last.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output owner_t     winner
);

    // winner selection from the request pair
    always_comb begin
        winner = OWN_I;
        case (req)
            2'b01:   winner = OWN_I;
            2'b10:   winner = OWN_D;
            2'b11:   winner = other_owner(last_owner);
            default: winner = OWN_I;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction-fetch (index 0) and data (index 1)
// masters, one whole transaction at a time, with an idle cycle after each.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
)(
    input  logic   clk,
    input  logic   rst,
    Mem_ift.Slave  imem_ift,
    Mem_ift.Slave  dmem_ift,
    Mem_ift.Master ram_ift
);

    localparam int WMASK_W = DATA_WIDTH / 8;

    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    owner_t last_owner_q, last_owner_d;
    logic   r_done_q, r_done_d;
    logic   w_done_q, w_done_d;

    logic [1:0] req_s;
    owner_t     winner_s;
    logic       own_ren_s;
    logic       own_wen_s;
    logic       r_ok_s;
    logic       w_ok_s;

    assign req_s = {dmem_ift.Mr.ren | dmem_ift.Mw.wen,
                    imem_ift.Mr.ren | imem_ift.Mw.wen};

    arb_rr2 u_rr (
        .req        (req_s),
        .last_owner (last_owner_q),
        .winner     (winner_s)
    );

    // live request lines of the current owner
    always_comb begin
        own_ren_s = 1'b0;
        own_wen_s = 1'b0;
        if (owner_q == OWN_D) begin
            own_ren_s = dmem_ift.Mr.ren;
            own_wen_s = dmem_ift.Mw.wen;
        end else begin
            own_ren_s = imem_ift.Mr.ren;
            own_wen_s = imem_ift.Mw.wen;
        end
    end

    // a channel is finished if never requested, already answered, or answered now
    assign r_ok_s = ~own_ren_s | r_done_q | ram_ift.Sr.rvalid;
    assign w_ok_s = ~own_wen_s | w_done_q | ram_ift.Sw.wvalid;

    // next-state, ownership and completion tracking
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        r_done_d     = r_done_q;
        w_done_d     = w_done_q;
        case (state_q)
            IDLE: begin
                r_done_d = 1'b0;
                w_done_d = 1'b0;
                if (req_s != 2'b00) begin
                    state_d = GRANT;
                    owner_d = winner_s;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!own_ren_s && !own_wen_s) begin
                    state_d  = RELEASE;
                    r_done_d = 1'b0;
                    w_done_d = 1'b0;
                end else if (r_ok_s && w_ok_s) begin
                    state_d      = RELEASE;
                    last_owner_d = owner_q;
                    r_done_d     = 1'b0;
                    w_done_d     = 1'b0;
                end else begin
                    r_done_d = r_done_q | ram_ift.Sr.rvalid;
                    w_done_d = w_done_q | ram_ift.Sw.wvalid;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                r_done_d = 1'b0;
                w_done_d = 1'b0;
            end
        endcase
    end

    // arbiter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            r_done_q     <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            r_done_q     <= r_done_d;
            w_done_q     <= w_done_d;
        end
    end

    // owner's port onto the RAM, RAM valids back to the owner only while granted
    always_comb begin
        ram_ift.Mr.ren    = 1'b0;
        ram_ift.Mr.raddr  = {ADDR_WIDTH{1'b0}};
        ram_ift.Mw.wen    = 1'b0;
        ram_ift.Mw.waddr  = {ADDR_WIDTH{1'b0}};
        ram_ift.Mw.wdata  = {DATA_WIDTH{1'b0}};
        ram_ift.Mw.wmask  = {WMASK_W{1'b0}};
        imem_ift.Sr.rdata  = ram_ift.Sr.rdata;
        imem_ift.Sr.rvalid = 1'b0;
        imem_ift.Sw.wvalid = 1'b0;
        dmem_ift.Sr.rdata  = ram_ift.Sr.rdata;
        dmem_ift.Sr.rvalid = 1'b0;
        dmem_ift.Sw.wvalid = 1'b0;
        if (state_q == GRANT) begin
            if (owner_q == OWN_D) begin
                ram_ift.Mr         = dmem_ift.Mr;
                ram_ift.Mw         = dmem_ift.Mw;
                dmem_ift.Sr.rvalid = ram_ift.Sr.rvalid;
                dmem_ift.Sw.wvalid = ram_ift.Sw.wvalid;
            end else begin
                ram_ift.Mr         = imem_ift.Mr;
                ram_ift.Mw         = imem_ift.Mw;
                imem_ift.Sr.rvalid = ram_ift.Sr.rvalid;
                imem_ift.Sw.wvalid = ram_ift.Sw.wvalid;
            end
        end else begin
            ram_ift.Mr.ren = 1'b0;
            ram_ift.Mw.wen = 1'b0;
        end
    end

endmodule
